four_to_ten_driver: RTL and testbench
=====================================

// Module: four_to_ten_driver
// PURPOSE
//  Sequential decoder paired with the 10-to-4 one-hot encoder.
//  - Accepts a 4-bit code 1..10 over a valid/ready handshake.
//  - Drives the matching one-hot line of a 10-bit select bus for HOLD_CYCLES cycles.
//  - Follows with one all-zero break-before-make cycle, then accepts the next code.
//  - Codes 0 and 11..15 are rejected and counted. 15 (4'b1111) is the encoder's "no/invalid line" marker.
// PARAMETERS
//  OUT_W        10  one-hot bus width; code n (1..OUT_W) drives bit n-1
//  CODE_W       4   code width
//  HOLD_CYCLES  4   cycles a one-hot line stays asserted; legal range >=1
//  ERR_CNT_W    8   width of saturating error counter
// PORTS
//  clk         in   1          rising-edge clock
//  rst         in   1          synchronous, active-high reset
//  in_valid    in   1          in_code is valid
//  in_ready    out  1          block can accept a code (high only in IDLE)
//  in_code     in   CODE_W     code to decode
//  out_onehot  out  OUT_W      registered one-hot select bus; all-zero when not driving
//  out_active  out  1          high while out_onehot is nonzero (DRIVE state)
//  out_done    out  1          1-cycle pulse in the GAP cycle after each drive
//  err_pulse   out  1          1-cycle pulse, registered, for each rejected code
//  err_count   out  ERR_CNT_W  saturating count of rejected codes
// BEHAVIOUR
//  Reset:
//  - All outputs are 0 after reset, except in_ready = 1 (state IDLE).
//  - err_count and the hold counter clear to 0.
//  - rst is sampled at every edge and overrides everything.
//  - Reset mid-DRIVE or mid-GAP forces out_onehot = 0 at that edge, with no out_done.
//  Handshake:
//  - Accept = in_valid & in_ready at a rising edge.
//  - in_valid with in_ready low is ignored. There is no buffering; the source holds.
//  States:
//  - IDLE: in_ready = 1.
//    - Accept of valid code n (1..OUT_W): go to DRIVE.
//      - Same edge: out_onehot <= 1<<(n-1), hold counter <= HOLD_CYCLES-1.
//      - Latency: 1 cycle from the accept edge to the bus.
//    - Accept of invalid code: err_pulse <= 1 for one cycle.
//      - err_count increments and saturates at all-ones.
//      - Stays in IDLE with in_ready still 1; bus untouched.
//  - DRIVE: in_ready = 0, out_active = 1.
//    - counter != 0: decrement.
//    - counter == 0: go to GAP, out_onehot <= 0, out_done <= 1.
//    - Result: the line is high for exactly HOLD_CYCLES cycles.
//  - GAP: in_ready = 0, out_onehot = 0, out_done = 1 for this cycle only. Next edge goes to IDLE.
//  Throughput and invariants:
//  - Throughput: one code per HOLD_CYCLES+2 cycles.
//  - out_onehot always has at most one bit set. It never switches directly from one line to another.
//  - Codes above OUT_W are invalid even when CODE_W could encode them.
//  - Out-of-range or X codes never reach the bus.
// STRUCTURE
//  Shared package (four_to_ten_pkg):
//  - OUT_W and CODE_W defaults.
//  - CODE_INVALID = 4'b1111.
//  - State encoding: IDLE = 2'd0, DRIVE = 2'd1, GAP = 2'd2.
//  - The same package serves the encoder side.
//  Sub-module code_to_onehot (combinational):
//  - Takes the code and produces onehot[OUT_W-1:0] plus a code_ok flag.
//  - The top level holds the FSM, hold counter, output registers and error counter.
//  - Hold counter width = $clog2(HOLD_CYCLES+1).
// TESTING
//  1. Reset: assert rst 3 cycles. Every cycle: out_onehot = 0, in_ready = 1, err_count = 0.
//  2. Accept code 4'b0011:
//     - out_onehot = 10'b00_0000_0100 on the next 4 cycles.
//     - Then 1 zero cycle with out_done = 1, then in_ready = 1.
//  3. Hold in_valid high with codes 1 then 10 back-to-back:
//     - 10'b00_0000_0001 for 4 cycles, then 0 for 1 cycle.
//     - Then 10'b10_0000_0000 for 4 cycles.
//     - Second code accepted only when in_ready = 1.
//  4. Invalid codes 0, 11, 15 in consecutive cycles:
//     - 3 err_pulses, err_count = 3, out_onehot stays 0, in_ready stays 1.
//     - Then 260 invalid codes: err_count saturates at 255.
//  5. Reset mid-operation: accept code 5, assert rst on the 2nd DRIVE cycle.
//     - Next cycle out_onehot = 0, out_done = 0, in_ready = 1.
//  6. Sweep: all 16 codes with random in_valid gaps, checked against a scoreboard model.
//     - Sweep 2: HOLD_CYCLES = 1; a line is high exactly 1 cycle per code.

Source files
------------

// File: rtl/four_to_ten_pkg.sv
// rtl/four_to_ten_pkg.sv - shared widths, marker code and state encoding for the 4-to-10 driver and its encoder
package four_to_ten_pkg;

    localparam int         OUT_W_DEF    = 10;
    localparam int         CODE_W_DEF   = 4;
    localparam logic [3:0] CODE_INVALID = 4'b1111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/code_to_onehot.sv
// rtl/code_to_onehot.sv - combinational decode of a 1-based code into a one-hot line plus a code_ok flag
module code_to_onehot
    import four_to_ten_pkg::*;
#(
    parameter int OUT_W  = OUT_W_DEF,
    parameter int CODE_W = CODE_W_DEF
) (
    input  logic [CODE_W-1:0] code,
    output logic [OUT_W-1:0]  onehot,
    output logic              code_ok
);

    // Equality per line: an X or out-of-range code matches nothing and decodes as invalid.
    always_comb begin
        onehot  = '0;
        code_ok = 1'b0;
        for (int i = 0; i < OUT_W; i++) begin
            if (code == CODE_W'(i + 1)) begin
                onehot[i] = 1'b1;
                code_ok   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/four_to_ten_driver.sv
// rtl/four_to_ten_driver.sv - handshaked code-to-one-hot driver with timed hold, break-before-make gap and error count
module four_to_ten_driver
    import four_to_ten_pkg::*;
#(
    parameter int OUT_W       = OUT_W_DEF,
    parameter int CODE_W      = CODE_W_DEF,
    parameter int HOLD_CYCLES = 4,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CODE_W-1:0]    in_code,
    output logic [OUT_W-1:0]     out_onehot,
    output logic                 out_active,
    output logic                 out_done,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int               CNT_W     = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

    state_t                 state_q;
    logic [CNT_W-1:0]       hold_q;
    logic [OUT_W-1:0]       onehot_q;
    logic                   ready_q;
    logic                   active_q;
    logic                   done_q;
    logic                   err_q;
    logic [ERR_CNT_W-1:0]   err_cnt_q;
    logic [ERR_CNT_W-1:0]   err_cnt_d;
    logic [OUT_W-1:0]       dec_onehot;
    logic                   dec_ok;
    logic                   accept;

    code_to_onehot #(
        .OUT_W  (OUT_W),
        .CODE_W (CODE_W)
    ) u_dec (
        .code    (in_code),
        .onehot  (dec_onehot),
        .code_ok (dec_ok)
    );

    assign accept    = in_valid & ready_q;
    assign err_cnt_d = (&err_cnt_q) ? err_cnt_q : err_cnt_q + ERR_CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            onehot_q  <= '0;
            ready_q   <= 1'b1;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (dec_ok) begin
                            state_q  <= DRIVE;
                            onehot_q <= dec_onehot;
                            hold_q   <= HOLD_LOAD;
                            ready_q  <= 1'b0;
                            active_q <= 1'b1;
                        end else begin
                            err_q     <= 1'b1;
                            err_cnt_q <= err_cnt_d;
                        end
                    end
                end
                DRIVE: begin
                    if (hold_q != '0) begin
                        hold_q <= hold_q - CNT_W'(1);
                    end else begin
                        state_q  <= GAP;
                        onehot_q <= '0;
                        active_q <= 1'b0;
                        done_q   <= 1'b1;
                    end
                end
                GAP: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q  <= IDLE;
                    onehot_q <= '0;
                    active_q <= 1'b0;
                    ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready   = ready_q;
    assign out_onehot = onehot_q;
    assign out_active = active_q;
    assign out_done   = done_q;
    assign err_pulse  = err_q;
    assign err_count  = err_cnt_q;

endmodule

// File: tb/tb_four_to_ten_driver.sv
// tb/tb_four_to_ten_driver.sv - scoreboard bench for four_to_ten_driver at HOLD_CYCLES 4 (u_a) and 1 (u_b)
module tb_four_to_ten_driver;

    typedef struct packed {
        logic       k;
        logic       is_err;
        logic [9:0] oh;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [1:0]      vld = '0;
    logic [1:0][3:0] cd  = '0;
    wire  [1:0]      rdy;
    wire  [1:0]      act;
    wire  [1:0]      dn;
    wire  [1:0]      ep;
    wire  [1:0][9:0] oh;
    wire  [1:0][7:0] ec;

    int         vectors     = 0;
    int         miscompares = 0;
    exp_t       sb[$];
    logic [9:0] prev[2]     = '{10'd0, 10'd0};
    int         run[2]      = '{0, 0};
    int         err_seen[2] = '{0, 0};
    bit         mon_en[2]   = '{1'b1, 1'b1};

    four_to_ten_driver #(.HOLD_CYCLES(4)) u_a (
        .clk(clk), .rst(rst), .in_valid(vld[0]), .in_ready(rdy[0]), .in_code(cd[0]),
        .out_onehot(oh[0]), .out_active(act[0]), .out_done(dn[0]),
        .err_pulse(ep[0]), .err_count(ec[0])
    );

    four_to_ten_driver #(.HOLD_CYCLES(1)) u_b (
        .clk(clk), .rst(rst), .in_valid(vld[1]), .in_ready(rdy[1]), .in_code(cd[1]),
        .out_onehot(oh[1]), .out_active(act[1]), .out_done(dn[1]),
        .err_pulse(ep[1]), .err_count(ec[1])
    );

    always #5 clk = ~clk;

    function automatic exp_t mk_exp(input int k, input logic [3:0] c);
        exp_t e;
        e.k = k[0];
        if (c >= 4'd1 && c <= 4'd10) begin
            e.is_err = 1'b0;
            e.oh     = 10'd1 << (c - 4'd1);
        end else begin
            e.is_err = 1'b1;
            e.oh     = 10'd0;
        end
        return e;
    endfunction

    task automatic mon_step(input int k, input int hold);
        logic [9:0] o;
        o = oh[k];
        if (!mon_en[k] || rst) begin
            prev[k] = '0;
            run[k]  = 0;
            return;
        end
        if (ep[k] === 1'b1) begin
            vectors++;
            if (sb.size() == 0 || sb[0].k != k[0] || !sb[0].is_err) begin
                miscompares++;
                $display("FAIL err_pulse_unexpected dut%0d: got pulse, queue size %0d", k, sb.size());
            end else begin
                void'(sb.pop_front());
                err_seen[k]++;
            end
        end
        if (o !== 10'd0 && prev[k] === 10'd0) begin
            vectors++;
            if (sb.size() == 0 || sb[0].k != k[0] || sb[0].is_err || sb[0].oh !== o) begin
                miscompares++;
                $display("FAIL line_start dut%0d: got %b expected %b", k, o,
                         (sb.size() != 0) ? sb[0].oh : 10'd0);
            end
            if (sb.size() != 0) void'(sb.pop_front());
            run[k] = 1;
        end else if (o !== 10'd0) begin
            vectors++;
            if (o !== prev[k]) begin
                miscompares++;
                $display("FAIL line_switch dut%0d: got %b after %b", k, o, prev[k]);
            end
            run[k]++;
        end else if (prev[k] !== 10'd0) begin
            vectors++;
            if (run[k] != hold || dn[k] !== 1'b1) begin
                miscompares++;
                $display("FAIL hold_len dut%0d: got %0d cycles done=%b expected %0d cycles done=1",
                         k, run[k], dn[k], hold);
            end
        end else begin
            vectors++;
            if (dn[k] !== 1'b0) begin
                miscompares++;
                $display("FAIL stray_done dut%0d: got out_done=%b expected 0", k, dn[k]);
            end
        end
        vectors++;
        if ($countones(o) > 1 || act[k] !== (o !== 10'd0) || (o !== 10'd0 && rdy[k] !== 1'b0)) begin
            miscompares++;
            $display("FAIL invariant dut%0d: onehot=%b active=%b ready=%b", k, o, act[k], rdy[k]);
        end
        prev[k] = o;
    endtask

    always @(negedge clk) begin
        mon_step(0, 4);
        mon_step(1, 1);
    end

    task automatic sync_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int k, input logic [3:0] c);
        int waited;
        waited = 0;
        vld[k] = 1'b1;
        cd[k]  = c;
        @(negedge clk);
        while (rdy[k] !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (rdy[k] !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout dut%0d: in_ready=%b expected 1", k, rdy[k]);
        end else begin
            sb.push_back(mk_exp(k, c));
        end
        sync_edge();
        vld[k] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expectations expected 0", sb.size());
            sb.delete();
        end
        sync_edge();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            vectors++;
            if (oh[0] !== 10'd0 || rdy[0] !== 1'b1 || ec[0] !== 8'd0 || dn[0] !== 1'b0 || ep[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_state: onehot=%b ready=%b err_count=%0d done=%b err=%b expected 0/1/0/0/0",
                         oh[0], rdy[0], ec[0], dn[0], ep[0]);
            end
        end
        rst = 1'b0;
        sync_edge();
    endtask

    task automatic test_single_code();
        send(0, 4'b0011);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (oh[0] !== 10'b00_0000_0100) begin
                miscompares++;
                $display("FAIL code3_drive: cycle %0d got %b expected 0000000100", i, oh[0]);
            end
        end
        @(negedge clk);
        vectors++;
        if (oh[0] !== 10'd0 || dn[0] !== 1'b1 || rdy[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL code3_gap: onehot=%b done=%b ready=%b expected 0/1/0", oh[0], dn[0], rdy[0]);
        end
        @(negedge clk);
        vectors++;
        if (rdy[0] !== 1'b1 || dn[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL code3_idle: ready=%b done=%b expected 1/0", rdy[0], dn[0]);
        end
        sync_edge();
    endtask

    task automatic test_back_to_back();
        send(0, 4'd1);
        vld[0] = 1'b1;
        cd[0]  = 4'd10;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (oh[0] !== 10'b00_0000_0001 || rdy[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL b2b_first: cycle %0d got %b ready=%b expected 0000000001 ready=0", i, oh[0], rdy[0]);
            end
        end
        @(negedge clk);
        vectors++;
        if (oh[0] !== 10'd0 || rdy[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_gap: got %b ready=%b expected 0 ready=0", oh[0], rdy[0]);
        end
        send(0, 4'd10);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (oh[0] !== 10'b10_0000_0000) begin
                miscompares++;
                $display("FAIL b2b_second: cycle %0d got %b expected 1000000000", i, oh[0]);
            end
        end
        drain();
    endtask

    task automatic test_invalid();
        int base;
        logic [3:0] bad[6];
        bad  = '{4'd0, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
        base = err_seen[0];
        send(0, 4'd0);
        send(0, 4'd11);
        send(0, 4'd15);
        @(negedge clk);
        #1;
        vectors++;
        if (ec[0] !== 8'd3 || err_seen[0] - base != 3 || oh[0] !== 10'd0 || rdy[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL invalid_three: err_count=%0d pulses=%0d onehot=%b ready=%b expected 3/3/0/1",
                     ec[0], err_seen[0] - base, oh[0], rdy[0]);
        end
        sync_edge();
        for (int i = 0; i < 260; i++) send(0, bad[$urandom_range(0, 5)]);
        @(negedge clk);
        #1;
        vectors++;
        if (ec[0] !== 8'd255 || oh[0] !== 10'd0) begin
            miscompares++;
            $display("FAIL err_saturate: err_count=%0d onehot=%b expected 255/0", ec[0], oh[0]);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        mon_en[0] = 1'b0;
        send(0, 4'd5);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (oh[0] !== 10'd0 || dn[0] !== 1'b0 || rdy[0] !== 1'b1 || act[0] !== 1'b0 || ec[0] !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_mid: onehot=%b done=%b ready=%b active=%b err_count=%0d expected 0/0/1/0/0",
                     oh[0], dn[0], rdy[0], act[0], ec[0]);
        end
        sb.delete();
        mon_en[0] = 1'b1;
        sync_edge();
    endtask

    task automatic test_sweep(input int k);
        logic [3:0] c;
        for (int rep = 0; rep < 2; rep++) begin
            for (int i = 0; i < 16; i++) begin
                c = (rep == 0) ? 4'(i) : 4'($urandom_range(0, 15));
                repeat ($urandom_range(0, 3)) sync_edge();
                send(k, c);
            end
        end
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_code();
        test_back_to_back();
        test_invalid();
        test_reset_mid();
        test_sweep(0);
        test_sweep(1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
